// File: rtl/csr_timer_intc_if.sv
// CSR-side bus of the timer / interrupt-source stage: register write strobes
// in, timer state and interrupt status out.
interface csr_timer_intc_if;
    // Write strobes have no ready: a strobe that is high at a rising edge is
    // always accepted at that edge, and back-to-back strobes are legal.
    logic        tcfg_wen;
    logic [31:0] tcfg_wdata;
    logic        ticlr_wen;
    logic [31:0] ticlr_wdata;
    logic [1:0]  estat_is_soft;
    logic [12:0] ecfg_lie;
    logic        crmd_ie;
    logic [31:0] tcfg;
    logic [31:0] tval;
    logic        timer_int;
    logic [7:0]  is_hard;
    logic        ipi;
    logic [63:0] stable_cnt;
    logic        int_pending;

    modport master (
        output tcfg_wen, tcfg_wdata, ticlr_wen, ticlr_wdata,
        output estat_is_soft, ecfg_lie, crmd_ie,
        input  tcfg, tval, timer_int, is_hard, ipi, stable_cnt, int_pending
    );

    modport slave (
        input  tcfg_wen, tcfg_wdata, ticlr_wen, ticlr_wdata,
        input  estat_is_soft, ecfg_lie, crmd_ie,
        output tcfg, tval, timer_int, is_hard, ipi, stable_cnt, int_pending
    );
endinterface

// File: rtl/csr_timer_intc.sv
// LoongArch constant timer, 64-bit stable counter, interrupt-line synchronisers
// and the registered interrupt-pending request feeding the CSR file.
module csr_timer_intc #(
    parameter int TIMER_W     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic [7:0]      hw_int,
    input  logic            ipi_in,
    csr_timer_intc_if.slave bus
);
    localparam logic [32:0] VAL_LIMIT = 33'd1 << TIMER_W;
    localparam logic [31:0] VAL_MASK  = 32'(VAL_LIMIT - 33'd1);

    logic [31:0] tcfg_q;
    logic [31:0] tval_q;
    logic        armed_q;
    logic        timer_int_q;
    logic [63:0] stable_cnt_q;
    logic [SYNC_STAGES-1:0][8:0] sync_q;
    logic        int_pending_q;

    logic        tmr_en;
    logic        tmr_periodic;
    logic        tmr_event;
    logic        tmr_clear;
    logic [31:0] reload_val;
    logic [31:0] wr_val;
    logic [31:0] tval_d;
    logic        armed_d;
    logic        timer_int_d;
    logic [12:0] is_vec;
    logic        int_pending_d;
    logic        unused_bits;

    assign tmr_en       = tcfg_q[0];
    assign tmr_periodic = tcfg_q[1];
    assign reload_val   = tcfg_q & ~32'd3;
    assign wr_val       = bus.tcfg_wdata & VAL_MASK;
    assign tmr_event    = tmr_en & armed_q & (tval_q == '0);
    assign tmr_clear    = bus.ticlr_wen & bus.ticlr_wdata[0];
    assign unused_bits  = ^bus.ticlr_wdata[31:1];

    // A TCFG write always reloads tval/armed, even on the edge an event fires.
    always_comb begin
        tval_d  = tval_q;
        armed_d = armed_q;
        if (bus.tcfg_wen) begin
            tval_d  = wr_val & ~32'd3;
            armed_d = bus.tcfg_wdata[0];
        end else if (tmr_event) begin
            if (tmr_periodic) begin
                tval_d = reload_val;
            end else begin
                armed_d = 1'b0;
            end
        end else if (tmr_en && (tval_q != '0)) begin
            tval_d = tval_q - 32'd1;
        end
    end

    // Set beats clear when an event and a TICLR land on the same edge.
    assign timer_int_d = tmr_event | (timer_int_q & ~tmr_clear);

    assign is_vec = {sync_q[SYNC_STAGES-1][8], timer_int_q, 1'b0,
                     sync_q[SYNC_STAGES-1][7:0], bus.estat_is_soft};
    assign int_pending_d = bus.crmd_ie & |(is_vec & bus.ecfg_lie);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tcfg_q        <= '0;
            tval_q        <= '0;
            armed_q       <= 1'b0;
            timer_int_q   <= 1'b0;
            stable_cnt_q  <= '0;
            sync_q        <= '0;
            int_pending_q <= 1'b0;
        end else begin
            if (bus.tcfg_wen) begin
                tcfg_q <= wr_val;
            end
            tval_q        <= tval_d;
            armed_q       <= armed_d;
            timer_int_q   <= timer_int_d;
            stable_cnt_q  <= stable_cnt_q + 64'd1;
            sync_q        <= {sync_q[SYNC_STAGES-2:0], {ipi_in, hw_int}};
            int_pending_q <= int_pending_d;
        end
    end

    assign bus.tcfg        = tcfg_q;
    assign bus.tval        = tval_q;
    assign bus.timer_int   = timer_int_q;
    assign bus.is_hard     = sync_q[SYNC_STAGES-1][7:0];
    assign bus.ipi         = sync_q[SYNC_STAGES-1][8];
    assign bus.stable_cnt  = stable_cnt_q;
    assign bus.int_pending = int_pending_q;
endmodule
